gfx_mem_arbiter: RTL and testbench

Frame-buffer memory arbiter directly downstream of the drawing engines: accepts read/write requests from up to NUM_PORTS engines (fill-rect engine on port 1), grants one per cycle in round-robin order, and drives a single-port synchronous SRAM. Read data is broadcast to all engines on a shared bus with a one-cycle transfer strobe and a one-hot owner tag. Write requests are fire-and-forget.

---
 rtl/gfx_pkg.sv | 18 +
 rtl/gfx_rr_pick.sv | 31 +++
 rtl/gfx_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_gfx_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics memory subsystem: request opcodes,
// engine port assignments and default frame-buffer bus widths.
package gfx_pkg;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } gfx_op_e;

   localparam int PORT_DISPLAY   = 0;
   localparam int PORT_FILL_RECT = 1;
   localparam int PORT_LINE      = 2;
   localparam int PORT_BLIT      = 3;

   localparam int DEFAULT_AW = 16;
   localparam int DEFAULT_DW = 32;

endpackage

// File: rtl/gfx_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first asserted
// request at or after ptr, wrapping around the port count.
import gfx_pkg::*;

module gfx_rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int PW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        ptr,
   output logic [NUM_PORTS-1:0] grant
);

   int   idx;
   logic found;

   // Scan ports starting at ptr; the first requester wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(ptr) + i) % NUM_PORTS;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gfx_mem_arbiter.sv
// Frame-buffer SRAM arbiter: round-robin grant of one engine request per
// cycle, a registered SRAM command stage, and a read-return broadcast stage
// tagged with the one-hot owner of each returning read.
import gfx_pkg::*;

module gfx_mem_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int AW        = DEFAULT_AW,
   parameter int DW        = DEFAULT_DW
) (
   input  logic                      clk,
   input  logic                      rst_,
   input  logic [NUM_PORTS*DW-1:0]   req_data,
   input  logic [NUM_PORTS*AW-1:0]   req_addr,
   input  logic [NUM_PORTS*DW/8-1:0] req_wben,
   input  logic [NUM_PORTS-1:0]      req_op,
   input  logic [NUM_PORTS-1:0]      req_rts,
   output logic [NUM_PORTS-1:0]      req_rtr,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [AW-1:0]             mem_addr,
   output logic [DW-1:0]             mem_wdata,
   output logic [DW/8-1:0]           mem_wben,
   input  logic [DW-1:0]             mem_rdata,
   output logic [DW-1:0]             bcast_data,
   output logic                      bcast_xfc,
   output logic [NUM_PORTS-1:0]      bcast_owner,
   output logic                      busy
);

   localparam int BW = DW / 8;
   localparam int PW = $clog2(NUM_PORTS);

   logic [PW-1:0]        ptr;
   logic [PW-1:0]        ptr_nxt;
   logic [NUM_PORTS-1:0] grant;
   logic                 accept;

   logic [AW-1:0]        sel_addr;
   logic [DW-1:0]        sel_data;
   logic [BW-1:0]        sel_wben;
   logic                 sel_op;

   logic                 vld_p1;
   logic                 rd_p1;
   logic [NUM_PORTS-1:0] owner_p1;
   logic                 vld_p2;
   logic [NUM_PORTS-1:0] owner_p2;

   gfx_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PW        (PW)
   ) u_pick (
      .req   (req_rts),
      .ptr   (ptr),
      .grant (grant)
   );

   assign req_rtr = grant;
   assign accept  = |grant;

   // Select the granted port's fields and the pointer value that follows it.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_wben = '0;
      sel_op   = OP_READ;
      ptr_nxt  = ptr;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
            sel_wben = req_wben[i*BW +: BW];
            sel_op   = req_op[i];
            ptr_nxt  = PW'((i + 1) % NUM_PORTS);
         end
      end
   end

   // Priority pointer advances past the port that just transferred.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) ptr <= '0;
      else       ptr <= ptr_nxt;
   end

   // Stage 1: registered SRAM command; address and data hold when idle.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         vld_p1    <= 1'b0;
         rd_p1     <= 1'b0;
         owner_p1  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wben  <= '0;
      end else begin
         vld_p1   <= accept;
         rd_p1    <= accept && (sel_op == OP_READ);
         owner_p1 <= accept ? grant : '0;
         if (accept) begin
            mem_we    <= (sel_op == OP_WRITE);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_data;
            mem_wben  <= (sel_op == OP_WRITE) ? sel_wben : '0;
         end else begin
            mem_we   <= 1'b0;
            mem_wben <= '0;
         end
      end
   end

   // Stage 2: read returns only; SRAM data arrives now and is passed through.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         vld_p2   <= 1'b0;
         owner_p2 <= '0;
      end else begin
         vld_p2   <= vld_p1 & rd_p1;
         owner_p2 <= (vld_p1 & rd_p1) ? owner_p1 : '0;
      end
   end

   assign mem_en      = vld_p1;
   assign bcast_xfc   = vld_p2;
   assign bcast_owner = owner_p2;
   assign bcast_data  = mem_rdata;
   assign busy        = vld_p1 | vld_p2;

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed bench for gfx_mem_arbiter with a behavioural one-cycle SRAM.
import gfx_pkg::*;

module tb_gfx_mem_arbiter;

   localparam int NP = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              rst_ = 1'b0;
   logic [NP*DW-1:0]  req_data = '0;
   logic [NP*AW-1:0]  req_addr = '0;
   logic [NP*BW-1:0]  req_wben = '0;
   logic [NP-1:0]     req_op = '0;
   logic [NP-1:0]     req_rts = '0;
   logic [NP-1:0]     req_rtr;
   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [BW-1:0]     mem_wben;
   logic [DW-1:0]     mem_rdata;
   logic [DW-1:0]     bcast_data;
   logic              bcast_xfc;
   logic [NP-1:0]     bcast_owner;
   logic              busy;

   logic [31:0]       sram [0:255];
   logic              pre_en = 1'b0;
   logic [7:0]        pre_addr = '0;
   logic [31:0]       pre_data = '0;

   int checks = 0;
   int errors = 0;

   gfx_mem_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_        (rst_),
      .req_data    (req_data),
      .req_addr    (req_addr),
      .req_wben    (req_wben),
      .req_op      (req_op),
      .req_rts     (req_rts),
      .req_rtr     (req_rtr),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wben    (mem_wben),
      .mem_rdata   (mem_rdata),
      .bcast_data  (bcast_data),
      .bcast_xfc   (bcast_xfc),
      .bcast_owner (bcast_owner),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Single-port synchronous SRAM with byte enables; preload port for the bench.
   always @(posedge clk) begin
      if (pre_en) sram[pre_addr] <= pre_data;
      else if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < BW; b++)
               if (mem_wben[b]) sram[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= sram[mem_addr[7:0]];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic set_req(input int p, input logic op, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] be);
      req_rts[p]           = 1'b1;
      req_op[p]            = op;
      req_addr[p*AW +: AW] = a;
      req_data[p*DW +: DW] = d;
      req_wben[p*BW +: BW] = be;
   endtask

   task automatic clr_req();
      req_rts = '0;
   endtask

   task automatic do_reset();
      clr_req();
      rst_ = 1'b0;
      tick();
      tick();
      rst_ = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clr_req();
      rst_ = 1'b0;
      sample();
      checks++; if (req_rtr !== 4'b0000) begin errors++; $display("FAIL rst_rtr: got %b want 0000", req_rtr); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      checks++; if (mem_wben !== 4'h0) begin errors++; $display("FAIL rst_mem_wben: got %b want 0000", mem_wben); end
      checks++; if (bcast_xfc !== 1'b0) begin errors++; $display("FAIL rst_xfc: got %b want 0", bcast_xfc); end
      checks++; if (bcast_owner !== 4'b0000) begin errors++; $display("FAIL rst_owner: got %b want 0000", bcast_owner); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      tick();
      rst_ = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      preload(8'h10, 32'hDEADBEEF);
      set_req(PORT_FILL_RECT, OP_READ, 16'h0010, 32'h0, 4'hF);
      sample();
      checks++; if (req_rtr !== 4'b0010) begin errors++; $display("FAIL sr_rtr: got %b want 0010", req_rtr); end
      tick();
      clr_req();
      sample();
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL sr_mem_en: got %b want 1", mem_en); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sr_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL sr_mem_addr: got %h want 0010", mem_addr); end
      checks++; if (mem_wben !== 4'h0) begin errors++; $display("FAIL sr_mem_wben: got %b want 0000", mem_wben); end
      checks++; if (bcast_xfc !== 1'b0) begin errors++; $display("FAIL sr_early_xfc: got %b want 0", bcast_xfc); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_busy1: got %b want 1", busy); end
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b1) begin errors++; $display("FAIL sr_xfc: got %b want 1", bcast_xfc); end
      checks++; if (bcast_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_data: got %h want deadbeef", bcast_data); end
      checks++; if (bcast_owner !== 4'b0010) begin errors++; $display("FAIL sr_owner: got %b want 0010", bcast_owner); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL sr_mem_idle: got %b want 0", mem_en); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_busy2: got %b want 1", busy); end
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b0) begin errors++; $display("FAIL sr_xfc_end: got %b want 0", bcast_xfc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_busy_end: got %b want 0", busy); end
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL sr_addr_hold: got %h want 0010", mem_addr); end
      tick();
   endtask

   task automatic test_byte_write();
      preload(8'h20, 32'hAAAAAAAA);
      // ptr sits at 2 here; port 1 alone must still win after the wrap
      set_req(PORT_FILL_RECT, OP_WRITE, 16'h0020, 32'h11223344, 4'b0101);
      sample();
      checks++; if (req_rtr !== 4'b0010) begin errors++; $display("FAIL bw_rtr: got %b want 0010", req_rtr); end
      tick();
      clr_req();
      sample();
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL bw_en_we: got en=%b we=%b want 1/1", mem_en, mem_we); end
      checks++; if (mem_addr !== 16'h0020) begin errors++; $display("FAIL bw_addr: got %h want 0020", mem_addr); end
      checks++; if (mem_wdata !== 32'h11223344) begin errors++; $display("FAIL bw_wdata: got %h want 11223344", mem_wdata); end
      checks++; if (mem_wben !== 4'b0101) begin errors++; $display("FAIL bw_wben: got %b want 0101", mem_wben); end
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b0) begin errors++; $display("FAIL bw_no_xfc: got %b want 0", bcast_xfc); end
      checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_wben !== 4'h0) begin errors++; $display("FAIL bw_idle: got en=%b we=%b wben=%b want 0/0/0000", mem_en, mem_we, mem_wben); end
      checks++; if (mem_wdata !== 32'h11223344) begin errors++; $display("FAIL bw_wdata_hold: got %h want 11223344", mem_wdata); end
      // write with no byte lanes enabled: accepted, touches nothing
      set_req(PORT_DISPLAY, OP_WRITE, 16'h0020, 32'hFFFFFFFF, 4'b0000);
      sample();
      checks++; if (req_rtr !== 4'b0001) begin errors++; $display("FAIL bw0_rtr: got %b want 0001", req_rtr); end
      tick();
      clr_req();
      sample();
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wben !== 4'h0) begin errors++; $display("FAIL bw0_cmd: got en=%b we=%b wben=%b want 1/1/0000", mem_en, mem_we, mem_wben); end
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b0) begin errors++; $display("FAIL bw0_no_xfc: got %b want 0", bcast_xfc); end
      set_req(PORT_FILL_RECT, OP_READ, 16'h0020, 32'h0, 4'h0);
      sample();
      checks++; if (req_rtr !== 4'b0010) begin errors++; $display("FAIL bwr_rtr: got %b want 0010", req_rtr); end
      tick();
      clr_req();
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b1 || bcast_data !== 32'hAA22AA44) begin errors++; $display("FAIL bwr_data: got xfc=%b data=%h want 1/aa22aa44", bcast_xfc, bcast_data); end
      checks++; if (bcast_owner !== 4'b0010) begin errors++; $display("FAIL bwr_owner: got %b want 0010", bcast_owner); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      do_reset();
      for (int p = 0; p < NP; p++) set_req(p, OP_READ, 16'(p), 32'h0, 4'h0);
      for (int c = 0; c < 8; c++) begin
         sample();
         exp = 4'b0001 << (c % 4);
         checks++; if (req_rtr !== exp) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", c, req_rtr, exp); end
         tick();
      end
      clr_req();
      tick(); tick(); tick();
   endtask

   task automatic test_ptr_wrap_skip();
      do_reset();
      set_req(PORT_LINE, OP_READ, 16'h0003, 32'h0, 4'h0);
      sample();
      checks++; if (req_rtr !== 4'b0100) begin errors++; $display("FAIL pw_setup: got %b want 0100", req_rtr); end
      tick();
      clr_req();
      // ptr now 3, ports 1 and 2 requesting
      set_req(PORT_FILL_RECT, OP_READ, 16'h0001, 32'h0, 4'h0);
      set_req(PORT_LINE, OP_READ, 16'h0002, 32'h0, 4'h0);
      sample();
      checks++; if (req_rtr !== 4'b0010) begin errors++; $display("FAIL pw_wrap: got %b want 0010", req_rtr); end
      tick();
      sample();
      checks++; if (req_rtr !== 4'b0100) begin errors++; $display("FAIL pw_next: got %b want 0100", req_rtr); end
      tick();
      clr_req();
      set_req(PORT_BLIT, OP_READ, 16'h0004, 32'h0, 4'h0);
      for (int c = 0; c < 3; c++) begin
         sample();
         checks++; if (req_rtr !== 4'b1000) begin errors++; $display("FAIL pw_solo%0d: got %b want 1000", c, req_rtr); end
         tick();
      end
      clr_req();
      tick(); tick(); tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      preload(8'h01, 32'h00001111);
      preload(8'h02, 32'h22220000);
      set_req(PORT_DISPLAY, OP_READ, 16'h0001, 32'h0, 4'h0);
      set_req(PORT_LINE, OP_READ, 16'h0002, 32'h0, 4'h0);
      sample();
      checks++; if (req_rtr !== 4'b0001) begin errors++; $display("FAIL bb_rtr0: got %b want 0001", req_rtr); end
      tick();
      req_rts[PORT_DISPLAY] = 1'b0;
      sample();
      checks++; if (req_rtr !== 4'b0100) begin errors++; $display("FAIL bb_rtr2: got %b want 0100", req_rtr); end
      checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0001) begin errors++; $display("FAIL bb_cmd0: got en=%b addr=%h want 1/0001", mem_en, mem_addr); end
      tick();
      clr_req();
      sample();
      checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL bb_cmd2: got en=%b addr=%h want 1/0002", mem_en, mem_addr); end
      checks++; if (bcast_xfc !== 1'b1 || bcast_owner !== 4'b0001 || bcast_data !== 32'h00001111) begin errors++; $display("FAIL bb_ret0: got xfc=%b own=%b data=%h want 1/0001/00001111", bcast_xfc, bcast_owner, bcast_data); end
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b1 || bcast_owner !== 4'b0100 || bcast_data !== 32'h22220000) begin errors++; $display("FAIL bb_ret2: got xfc=%b own=%b data=%h want 1/0100/22220000", bcast_xfc, bcast_owner, bcast_data); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL bb_idle: got %b want 0", mem_en); end
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b0) begin errors++; $display("FAIL bb_xfc_end: got %b want 0", bcast_xfc); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      // ptr is 3 after the previous test; port 1 wins after the wrap
      set_req(PORT_FILL_RECT, OP_READ, 16'h0010, 32'h0, 4'h0);
      sample();
      checks++; if (req_rtr !== 4'b0010) begin errors++; $display("FAIL rm_rtr: got %b want 0010", req_rtr); end
      tick();
      clr_req();
      sample();
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rm_mem_en: got %b want 1", mem_en); end
      rst_ = 1'b0;
      #1;
      checks++; if (mem_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async: got en=%b busy=%b want 0/0", mem_en, busy); end
      checks++; if (mem_addr !== 16'h0 || mem_we !== 1'b0 || mem_wben !== 4'h0) begin errors++; $display("FAIL rm_cmd: got addr=%h we=%b wben=%b want 0/0/0", mem_addr, mem_we, mem_wben); end
      tick();
      sample();
      checks++; if (bcast_xfc !== 1'b0 || bcast_owner !== 4'b0000) begin errors++; $display("FAIL rm_no_xfc: got xfc=%b own=%b want 0/0000", bcast_xfc, bcast_owner); end
      rst_ = 1'b1;
      tick();
      for (int p = 0; p < NP; p++) set_req(p, OP_READ, 16'h0, 32'h0, 4'h0);
      sample();
      checks++; if (req_rtr !== 4'b0001) begin errors++; $display("FAIL rm_ptr0: got %b want 0001", req_rtr); end
      checks++; if (bcast_xfc !== 1'b0) begin errors++; $display("FAIL rm_xfc_after: got %b want 0", bcast_xfc); end
      tick();
      clr_req();
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_byte_write();
      test_round_robin();
      test_ptr_wrap_skip();
      test_back_to_back();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
